input_vc_sa_scheduler: RTL

- Per-input-port switch-stage scheduler: picks one virtual channel per cycle to read out of the port's VC buffers toward the crossbar.
- Drives the port's selected-VC index and read-valid strobe.
- Round-robin arbitration over VCs that are requesting and hold downstream credit.
- Tracks per-VC downstream credits: decremented on grant, replenished by credit-return pulses.

---
 rtl/input_vc_sa_scheduler.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/input_vc_sa_scheduler.sv
// Input-port switch-allocation scheduler: round-robin VC pick gated by per-VC downstream credit.
// Optional wormhole packet lock is enabled by defining SA_PACKET_LOCK_EN.
module input_vc_sa_scheduler #(
  parameter int VC_NUM     = 2,
  parameter int VC_SIZE    = $clog2(VC_NUM),
  parameter int CREDIT_MAX = 8,
  parameter int CREDIT_W   = $clog2(CREDIT_MAX + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [VC_NUM-1:0]          req_i,
  input  logic [VC_NUM-1:0]          is_tail_i,
  input  logic [VC_NUM-1:0]          credit_ret_i,
  input  logic                       xb_ready_i,
  output logic [VC_SIZE-1:0]         sel_vc_o,
  output logic                       valid_o,
  output logic [VC_NUM*CREDIT_W-1:0] credit_o,
  output logic [VC_NUM-1:0]          error_o
);

  localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(CREDIT_MAX);

  logic [CREDIT_W-1:0] credit_q [VC_NUM];
  logic [CREDIT_W-1:0] credit_d [VC_NUM];
  logic [VC_NUM-1:0]   error_q, error_d;
  logic [VC_SIZE-1:0]  ptr_q, ptr_d;
  logic [VC_SIZE-1:0]  sel_q, sel_d;
  logic                valid_q, valid_d;

  logic [VC_NUM-1:0]   elig;
  logic [VC_NUM-1:0]   cand;
  logic                win_vld;
  logic [VC_SIZE-1:0]  win_idx;
  logic [VC_SIZE-1:0]  win_next;

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      elig[v] = req_i[v] & (credit_q[v] != '0);
    end
  end

`ifdef SA_PACKET_LOCK_EN
  logic               lock_q, lock_d;
  logic [VC_SIZE-1:0] lock_vc_q, lock_vc_d;

  // While a packet is in flight only its VC may compete, so other VCs cannot interleave flits.
  always_comb begin
    cand = elig;
    if (lock_q) begin
      cand = '0;
      cand[lock_vc_q] = elig[lock_vc_q];
    end
  end
`else
  logic unused_is_tail;
  assign unused_is_tail = ^is_tail_i;
  assign cand = elig;
`endif

  // Rotating priority scan starting at the pointer; first candidate found wins.
  // NOTE: every variable driven in a combinational block gets a default first so no latch is inferred.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    if (xb_ready_i) begin
      for (int k = 0; k < VC_NUM; k++) begin
        idx = (int'(ptr_q) + k) % VC_NUM;
        if (!win_vld && cand[idx]) begin
          win_vld = 1'b1;
          win_idx = VC_SIZE'(idx);
        end
      end
    end
  end

  assign win_next = VC_SIZE'((int'(win_idx) + 1) % VC_NUM);

  // Credit bookkeeping: a grant and a return on the same VC in one cycle cancel out.
  always_comb begin
    logic granted;
    granted = 1'b0;
    error_d = error_q;
    for (int v = 0; v < VC_NUM; v++) begin
      credit_d[v] = credit_q[v];
      granted     = win_vld && (win_idx == VC_SIZE'(v));
      if (granted && !credit_ret_i[v]) begin
        credit_d[v] = credit_q[v] - 1'b1;
      end else if (!granted && credit_ret_i[v]) begin
        if (credit_q[v] == CREDIT_FULL) begin
          error_d[v] = 1'b1;
        end else begin
          credit_d[v] = credit_q[v] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    valid_d = win_vld;
    sel_d   = win_vld ? win_idx : sel_q;
    ptr_d   = ptr_q;
`ifdef SA_PACKET_LOCK_EN
    lock_d    = lock_q;
    lock_vc_d = lock_vc_q;
    if (win_vld) begin
      if (is_tail_i[win_idx]) begin
        lock_d = 1'b0;
        ptr_d  = win_next;
      end else begin
        lock_d    = 1'b1;
        lock_vc_d = win_idx;
      end
    end
`else
    if (win_vld) begin
      ptr_d = win_next;
    end
`endif
  end

  // NOTE: sequential state is updated only with non-blocking assignments so all registers sample together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      sel_q   <= '0;
      ptr_q   <= '0;
      error_q <= '0;
      // NOTE: the credit array is a handful of flops, not a RAM, so it is reset to full along with the rest.
      for (int v = 0; v < VC_NUM; v++) begin
        credit_q[v] <= CREDIT_FULL;
      end
    end else begin
      valid_q <= valid_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      error_q <= error_d;
      for (int v = 0; v < VC_NUM; v++) begin
        credit_q[v] <= credit_d[v];
      end
    end
  end

`ifdef SA_PACKET_LOCK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q    <= 1'b0;
      lock_vc_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_vc_q <= lock_vc_d;
    end
  end
`endif

  for (genvar g = 0; g < VC_NUM; g++) begin : g_credit_out
    assign credit_o[g*CREDIT_W +: CREDIT_W] = credit_q[g];
  end

  assign valid_o  = valid_q;
  assign sel_vc_o = sel_q;
  assign error_o  = error_q;

endmodule
